// File: rtl/pe_arr_drain.sv
// -----------------------------------------------------------------------------
// pe_arr_drain
// Output drain stage for a ROWS x COLS PE array. A drain request snapshots the
// whole accumulator plane (masked by the per-PE valid flags) into a shadow
// bank, which is then streamed out one row per beat over valid/ready. The
// array is free to start its next accumulation as soon as the snapshot is
// taken.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   drain_req  - single-cycle snapshot request
//   outs       - flattened PE results, PE(r,c) at [(r*COLS+c)*DW +: DW]
//   outvalids  - per-PE valid flags, PE(r,c) at bit r*COLS+c
//   m_valid    - beat valid
//   m_ready    - downstream ready
//   m_data     - one row, column c at [c*DW +: DW]
//   m_mask     - per-column valid flags of the row
//   m_row      - row index of the current beat
//   m_last     - high on the beat carrying row ROWS-1
//   busy       - high while streaming
//   overrun    - sticky flag: a drain request was dropped
//   clr_err    - clears overrun (a simultaneous new overrun wins)
// -----------------------------------------------------------------------------
module pe_arr_drain #(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int DW   = 32,
   parameter int RW   = $clog2(ROWS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     drain_req,
   input  logic [ROWS*COLS*DW-1:0]  outs,
   input  logic [ROWS*COLS-1:0]     outvalids,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [COLS*DW-1:0]       m_data,
   output logic [COLS-1:0]          m_mask,
   output logic [RW-1:0]            m_row,
   output logic                     m_last,
   output logic                     busy,
   output logic                     overrun,
   input  logic                     clr_err
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

   state_t               r_state;
   logic [RW-1:0]        r_row;
   logic [COLS*DW-1:0]   r_bank [ROWS];
   logic [COLS-1:0]      r_mask [ROWS];
   logic                 r_overrun;

   logic                 w_stream;
   logic                 w_xfer;
   logic                 w_last_row;
   logic                 w_capture;
   logic                 w_drop;

   // Zero every column whose valid flag is low so invalid PEs read back as 0.
   function automatic logic [COLS*DW-1:0] mask_row(
      input logic [COLS*DW-1:0] data,
      input logic [COLS-1:0]    valid
   );
      logic [COLS*DW-1:0] res;
      res = {(COLS*DW){1'b0}};
      for (int c = 0; c < COLS; c++) begin
         res[c*DW +: DW] = data[c*DW +: DW] & {DW{valid[c]}};
      end
      return res;
   endfunction

   assign w_stream   = (r_state == ST_STREAM);
   assign w_xfer     = w_stream && m_ready;
   assign w_last_row = (r_row == LAST_ROW);
   // A request is accepted when idle, or exactly on the last-row transfer
   // (back-to-back); any other request during streaming is dropped.
   assign w_capture  = drain_req && (!w_stream || (w_xfer && w_last_row));
   assign w_drop     = drain_req && w_stream && !(w_xfer && w_last_row);

   // Streaming FSM and row counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_row   <= {RW{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (drain_req) begin
                  r_state <= ST_STREAM;
                  r_row   <= {RW{1'b0}};
               end
            end
            ST_STREAM: begin
               if (w_xfer) begin
                  if (!w_last_row) begin
                     r_row <= r_row + RW'(1);
                  end else if (drain_req) begin
                     r_row <= {RW{1'b0}};
                  end else begin
                     r_state <= ST_IDLE;
                     r_row   <= {RW{1'b0}};
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_row   <= {RW{1'b0}};
            end
         endcase
      end
   end

   // Shadow bank: loaded only on an accepted capture, otherwise held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < ROWS; r++) begin
            r_bank[r] <= {(COLS*DW){1'b0}};
            r_mask[r] <= {COLS{1'b0}};
         end
      end else if (w_capture) begin
         for (int r = 0; r < ROWS; r++) begin
            r_bank[r] <= mask_row(outs[r*COLS*DW +: COLS*DW],
                                  outvalids[r*COLS +: COLS]);
            r_mask[r] <= outvalids[r*COLS +: COLS];
         end
      end
   end

   // Sticky overrun flag; a new drop in the clearing cycle keeps it set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_drop | (r_overrun & ~clr_err);
      end
   end

   // Outputs are decoded purely from registered state.
   assign m_valid = w_stream;
   assign busy    = w_stream;
   assign m_row   = r_row;
   assign m_last  = w_stream && w_last_row;
   assign m_data  = r_bank[r_row];
   assign m_mask  = r_mask[r_row];
   assign overrun = r_overrun;

endmodule

// File: tb/tb_pe_arr_drain.sv
module tb_pe_arr_drain;

   logic          clk = 1'b0;
   logic          rst;
   logic          drain_req;
   logic [2047:0] outs;
   logic [63:0]   outvalids;
   logic          m_valid;
   logic          m_ready;
   logic [255:0]  m_data;
   logic [7:0]    m_mask;
   logic [2:0]    m_row;
   logic          m_last;
   logic          busy;
   logic          overrun;
   logic          clr_err;

   int tests = 0;
   int fails = 0;

   pe_arr_drain #(.ROWS(8), .COLS(8), .DW(32)) dut (
      .clk(clk), .rst(rst), .drain_req(drain_req), .outs(outs),
      .outvalids(outvalids), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_mask(m_mask), .m_row(m_row), .m_last(m_last),
      .busy(busy), .overrun(overrun), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pe_val(int pat, int r, int c);
      return 32'(pat * 16777216 + r * 256 + c);
   endfunction

   function automatic logic [255:0] exp_row(int pat, int r, logic [63:0] v);
      logic [255:0] res;
      res = 256'd0;
      for (int c = 0; c < 8; c++) begin
         res[c*32 +: 32] = v[r*8 + c] ? pe_val(pat, r, c) : 32'd0;
      end
      return res;
   endfunction

   task automatic load_outs(int pat);
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            outs[(r*8 + c)*32 +: 32] = pe_val(pat, r, c);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_row(string tag, int pat, int r, logic [63:0] v);
      chk({tag, "_valid"}, 256'(m_valid), 256'(1));
      chk({tag, "_busy"},  256'(busy),    256'(1));
      chk({tag, "_row"},   256'(m_row),   256'(r));
      chk({tag, "_data"},  m_data,        exp_row(pat, r, v));
      chk({tag, "_mask"},  256'(m_mask),  256'(v[r*8 +: 8]));
      chk({tag, "_last"},  256'(m_last),  256'(r == 7));
   endtask

   task automatic pulse_drain();
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
   endtask

   initial begin
      logic [255:0] sv_data;
      logic [7:0]   sv_mask;
      logic [2:0]   sv_row;
      logic         sv_last;
      logic         stalled;
      int           xfers;
      logic [63:0]  vmask;

      rst = 1'b1; drain_req = 1'b0; m_ready = 1'b0; clr_err = 1'b0;
      outs = '0; outvalids = '0;
      #2;
      chk("rst_valid", 256'(m_valid), 256'(0));
      chk("rst_busy",  256'(busy),    256'(0));
      chk("rst_ovr",   256'(overrun), 256'(0));
      chk("rst_row",   256'(m_row),   256'(0));
      chk("rst_last",  256'(m_last),  256'(0));
      chk("rst_data",  m_data,        256'd0);
      chk("rst_mask",  256'(m_mask),  256'(0));
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("idle_valid", 256'(m_valid), 256'(0));

      // Basic drain
      load_outs(0); outvalids = {64{1'b1}}; m_ready = 1'b1;
      pulse_drain();
      for (int k = 0; k < 8; k++) begin
         check_row("basic", 0, k, outvalids);
         if (k == 5) chk("basic_r5c3", 256'(m_data[3*32 +: 32]), 256'(32'h503));
         tick();
      end
      chk("basic_end_valid", 256'(m_valid), 256'(0));
      chk("basic_end_busy",  256'(busy),    256'(0));

      // Masking: PE(1,2) invalid
      vmask = 64'hFFFF_FFFF_FFFF_FBFF;
      load_outs(1); outvalids = vmask;
      pulse_drain();
      for (int k = 0; k < 8; k++) begin
         check_row("mask", 1, k, vmask);
         if (k == 1) begin
            chk("mask_r1", 256'(m_mask), 256'(8'hFB));
            chk("mask_r1c2", 256'(m_data[2*32 +: 32]), 256'(0));
         end
         tick();
      end
      chk("mask_end_valid", 256'(m_valid), 256'(0));

      // Back-pressure: ready 1,0,0,1,0,0,... with outs changed after capture
      load_outs(2); outvalids = {64{1'b1}};
      pulse_drain();
      load_outs(3);
      outvalids = 64'h0;
      xfers = 0; stalled = 1'b0;
      sv_data = '0; sv_mask = '0; sv_row = '0; sv_last = 1'b0;
      for (int cyc = 0; cyc < 60 && xfers < 8; cyc++) begin
         m_ready = ((cyc % 3) == 0);
         chk("bp_valid", 256'(m_valid), 256'(1));
         if (stalled) begin
            chk("bp_hold_data", m_data, sv_data);
            chk("bp_hold_mask", 256'(m_mask), 256'(sv_mask));
            chk("bp_hold_row",  256'(m_row),  256'(sv_row));
            chk("bp_hold_last", 256'(m_last), 256'(sv_last));
         end
         if (m_ready) begin
            chk("bp_row",  256'(m_row), 256'(xfers));
            chk("bp_data", m_data, exp_row(2, xfers, {64{1'b1}}));
            xfers++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            sv_data = m_data; sv_mask = m_mask; sv_row = m_row; sv_last = m_last;
         end
         tick();
      end
      m_ready = 1'b1;
      chk("bp_xfers", 256'(xfers), 256'(8));
      chk("bp_end_valid", 256'(m_valid), 256'(0));

      // Back-to-back and overrun
      outvalids = {64{1'b1}};
      load_outs(4);
      pulse_drain();
      for (int k = 0; k < 8; k++) begin
         check_row("b2b_a", 4, k, outvalids);
         if (k == 7) begin
            drain_req = 1'b1;
            load_outs(5);
         end
         tick();
         drain_req = 1'b0;
      end
      for (int k = 0; k < 8; k++) begin
         check_row("b2b_b", 5, k, outvalids);
         if (k <= 3) chk("b2b_ovr_lo", 256'(overrun), 256'(0));
         if (k >= 4) chk("b2b_ovr_hi", 256'(overrun), 256'(1));
         if (k == 3) begin
            drain_req = 1'b1;
            load_outs(6);
         end
         tick();
         drain_req = 1'b0;
      end
      chk("b2b_end_valid", 256'(m_valid), 256'(0));
      chk("b2b_end_ovr",   256'(overrun), 256'(1));
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_ovr", 256'(overrun), 256'(0));

      // Set-wins, then asynchronous reset during row 4
      load_outs(7);
      pulse_drain();
      check_row("rs", 7, 0, outvalids);
      tick();
      drain_req = 1'b1; clr_err = 1'b1;
      tick();
      drain_req = 1'b0; clr_err = 1'b0;
      chk("set_wins_ovr", 256'(overrun), 256'(1));
      tick(); tick();
      check_row("rs4", 7, 4, outvalids);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid", 256'(m_valid), 256'(0));
      chk("arst_busy",  256'(busy),    256'(0));
      chk("arst_row",   256'(m_row),   256'(0));
      chk("arst_ovr",   256'(overrun), 256'(0));
      chk("arst_data",  m_data,        256'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_valid", 256'(m_valid), 256'(0));
      chk("post_rst_row",   256'(m_row),   256'(0));
      load_outs(8);
      pulse_drain();
      for (int k = 0; k < 8; k++) begin
         check_row("restart", 8, k, outvalids);
         tick();
      end
      chk("restart_end_valid", 256'(m_valid), 256'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
